pipeline_stall_controller: RTL and testbench
============================================

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 The block SHALL have parameter DIV_LATENCY, default 8, giving the divider busy cycles; legal range 2..255.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 64, giving the maximum data-memory wait cycles before a fault; legal range 2..255.
REQ-003 The block SHALL have one clock, clk, and reset_n; reset_n SHALL be asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-007 Ports id_uses_rs and id_uses_rt, input, 1 bit each: the ID instruction reads rs or rt.
REQ-008 Port ex_load_instr, input, 1 bit: the EX instruction is a load.
REQ-009 Port ex_rf_enable, input, 1 bit: the EX instruction writes the register file.
REQ-010 Port rd_ex, input, 5 bits: destination register of the EX instruction.
REQ-011 Port branch_taken, input, 1 bit: the branch in ID resolved taken.
REQ-012 Port div_start, input, 1 bit: a divide enters EX this cycle.
REQ-013 Port mem_req, input, 1 bit: the MEM stage has a memory access pending.
REQ-014 Port mem_ready, input, 1 bit: memory completes the access this cycle.
REQ-015 Ports PC_LE, IFID_LE, IDEX_LE and EXMEM_LE, output, 1 bit each: pipeline register load enables.
REQ-016 Port control_select, output, 1 bit: 1 = inject a bubble (zero control) into ID/EX.
REQ-017 Port ifid_flush, output, 1 bit: clear IF/ID this cycle.
REQ-018 Port div_done, output, 1 bit: one-cycle pulse when the divide finishes.
REQ-019 Port mem_fault, output, 1 bit: sticky memory-timeout flag.
REQ-020 Port ctrl_state, output, 2 bits: current state (RUN=00, MEM_WAIT=01, DIV_BUSY=10, FAULT=11).
REQ-021 Port stall_cycles, output, 16 bits: saturating count of cycles with PC_LE=0.

Function
REQ-022 The block SHALL detect a memory stall when mem_req=1 and mem_ready=0, in any state except FAULT.
REQ-023 The block SHALL detect load-use when ex_load_instr, ex_rf_enable and rd_ex!=0 are all set, and either (id_uses_rs and id_rs==rd_ex) or (id_uses_rt and id_rt==rd_ex) holds.
REQ-024 Output priority SHALL be, combinationally, same cycle: FAULT, then memory stall, then DIV_BUSY, then load-use, then branch flush, then normal.
REQ-025 In FAULT or on a memory stall, PC_LE, IFID_LE, IDEX_LE and EXMEM_LE SHALL all be 0, with control_select=0 and ifid_flush=0.
REQ-026 In DIV_BUSY without a memory stall, PC_LE=0, IFID_LE=0, IDEX_LE=1, EXMEM_LE=1 and control_select=1.
REQ-027 On load-use in RUN without a memory stall, outputs SHALL match REQ-026 for that cycle only; there is no state change.
REQ-028 On branch_taken in RUN with no stall, outputs SHALL be: all enables 1, ifid_flush=1, control_select=0.
REQ-029 branch_taken during any stall SHALL be ignored.
REQ-030 Normal operation SHALL be: all enables 1, control_select=0, ifid_flush=0.
REQ-031 RUN to MEM_WAIT SHALL occur on a memory stall, and the wait counter SHALL be cleared.
REQ-032 MEM_WAIT SHALL increment the wait counter each cycle.
REQ-033 MEM_WAIT to RUN SHALL occur when mem_ready=1 or mem_req=0.
REQ-034 MEM_WAIT to FAULT SHALL occur when the wait counter reaches MEM_TIMEOUT-1 while still stalled.
REQ-035 RUN to DIV_BUSY SHALL occur on div_start with no memory stall; the busy counter SHALL load DIV_LATENCY-1.
REQ-036 The busy counter SHALL decrement every cycle in DIV_BUSY, including cycles with a memory stall.
REQ-037 On busy counter == 0: div_done=1 for that cycle; the next state is RUN, or MEM_WAIT if a memory stall is present.
REQ-038 When a memory stall begins in DIV_BUSY, the state SHALL stay DIV_BUSY; the memory stall SHALL still freeze outputs (REQ-025), and no timeout is counted.
REQ-039 div_start outside RUN SHALL be ignored.
REQ-040 FAULT SHALL be absorbing until reset; mem_fault=1 in FAULT.
REQ-041 stall_cycles SHALL increment on each cycle with PC_LE=0 and SHALL saturate at 16'hFFFF.

Reset
REQ-042 While reset_n=0, the state SHALL be RUN and all counters 0.
REQ-043 While reset_n=0, mem_fault=0, div_done=0, control_select=0, ifid_flush=0, and all enables =1.
REQ-044 Reset asserted mid-stall or mid-divide SHALL abort immediately, with no div_done pulse.

Verification
REQ-045 Load-use: ex_load_instr=1, ex_rf_enable=1, rd_ex=5, id_rs=5, id_uses_rs=1 -> one cycle PC_LE=0/IFID_LE=0/control_select=1, state stays 00, stall_cycles=1.
REQ-046 rd_ex=0 with the same inputs as REQ-045 -> no stall; branch_taken=1 gives ifid_flush=1.
REQ-047 Divide: div_start=1 with DIV_LATENCY=8 -> 8 cycles ctrl_state=10 with control_select=1, div_done on the 8th, then RUN.
REQ-048 Memory wait: mem_req=1 with mem_ready low for 3 cycles -> all enables 0 for 3 cycles, release on the mem_ready cycle, stall_cycles=3.
REQ-049 Timeout: mem_req=1 with mem_ready=0 for 64 cycles -> ctrl_state=11, mem_fault=1 held; only reset_n=0 clears it.
REQ-050 Counter saturation and mid-divide reset: preload to saturation -> stall_cycles holds at FFFF; reset_n=0 mid-divide -> RUN with no div_done.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - hazard/stall controller for a 5-stage pipeline
// Arbitrates memory waits, multi-cycle divide and load-use hazards into pipeline register enables.
module pipeline_stall_controller #(
   parameter int unsigned DIV_LATENCY = 8,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        ex_load_instr,
   input  logic        ex_rf_enable,
   input  logic [4:0]  rd_ex,
   input  logic        branch_taken,
   input  logic        div_start,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        PC_LE,
   output logic        IFID_LE,
   output logic        IDEX_LE,
   output logic        EXMEM_LE,
   output logic        control_select,
   output logic        ifid_flush,
   output logic        div_done,
   output logic        mem_fault,
   output logic [1:0]  ctrl_state,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      DIV_BUSY = 2'b10,
      FAULT    = 2'b11
   } state_t;

   localparam logic [7:0] DIV_LOAD     = 8'(DIV_LATENCY - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state;
   state_t      state_next;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_next;
   logic [7:0]  wait_inc;
   logic [7:0]  busy_cnt;
   logic [7:0]  busy_next;
   logic [15:0] stall_cnt;
   logic        mem_stall;
   logic        rs_hit;
   logic        rt_hit;
   logic        load_use;
   logic        div_pulse;

   assign mem_stall = mem_req & ~mem_ready & (state != FAULT);
   assign rs_hit    = id_uses_rs & (id_rs == rd_ex);
   assign rt_hit    = id_uses_rt & (id_rt == rd_ex);
   assign load_use  = ex_load_instr & ex_rf_enable & (rd_ex != 5'd0) & (rs_hit | rt_hit);
   assign wait_inc  = wait_cnt + 8'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
         busy_cnt <= 8'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
         busy_cnt <= busy_next;
      end
   end

   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      busy_next  = busy_cnt;
      div_pulse  = 1'b0;
      case (state)
         RUN: begin
            if (mem_stall) begin
               state_next = MEM_WAIT;
               wait_next  = 8'd0;
            end else if (div_start) begin
               state_next = DIV_BUSY;
               busy_next  = DIV_LOAD;
            end
         end
         MEM_WAIT: begin
            if (!mem_stall) begin
               state_next = RUN;
            end else begin
               wait_next = wait_inc;
               if (wait_inc == TIMEOUT_LAST) begin
                  state_next = FAULT;
               end
            end
         end
         DIV_BUSY: begin
            // The divider keeps counting through a memory stall; the wait timer starts only after it finishes.
            if (busy_cnt == 8'd0) begin
               div_pulse  = 1'b1;
               wait_next  = 8'd0;
               state_next = mem_stall ? MEM_WAIT : RUN;
            end else begin
               busy_next = busy_cnt - 8'd1;
            end
         end
         FAULT: begin
            state_next = FAULT;
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   always_comb begin
      PC_LE          = 1'b1;
      IFID_LE        = 1'b1;
      IDEX_LE        = 1'b1;
      EXMEM_LE       = 1'b1;
      control_select = 1'b0;
      ifid_flush     = 1'b0;
      if (!reset_n) begin
         PC_LE = 1'b1;
      end else if ((state == FAULT) || mem_stall) begin
         PC_LE    = 1'b0;
         IFID_LE  = 1'b0;
         IDEX_LE  = 1'b0;
         EXMEM_LE = 1'b0;
      end else if ((state == DIV_BUSY) || load_use) begin
         PC_LE          = 1'b0;
         IFID_LE        = 1'b0;
         control_select = 1'b1;
      end else if (branch_taken) begin
         ifid_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= 16'd0;
      end else if (!PC_LE && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   assign div_done     = div_pulse;
   assign mem_fault    = (state == FAULT);
   assign ctrl_state   = state;
   assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - randomized and directed checks of pipeline_stall_controller
// A cycle-level behavioural model predicts every output from the hazard rules.
module tb_pipeline_stall_controller;

   localparam int DL = 8;
   localparam int MT = 64;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  id_rs, id_rt, rd_ex;
   logic        id_uses_rs, id_uses_rt, ex_load_instr, ex_rf_enable;
   logic        branch_taken, div_start, mem_req, mem_ready;
   logic        PC_LE, IFID_LE, IDEX_LE, EXMEM_LE;
   logic        control_select, ifid_flush, div_done, mem_fault;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cycles;
   logic [25:0] dut_out;

   int total = 0;
   int bad   = 0;

   bit m_fault, m_waiting;
   int m_div_rem, m_wait_len, m_stall;

   pipeline_stall_controller #(.DIV_LATENCY(DL), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_load_instr(ex_load_instr), .ex_rf_enable(ex_rf_enable), .rd_ex(rd_ex),
      .branch_taken(branch_taken), .div_start(div_start),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IDEX_LE(IDEX_LE), .EXMEM_LE(EXMEM_LE),
      .control_select(control_select), .ifid_flush(ifid_flush),
      .div_done(div_done), .mem_fault(mem_fault),
      .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   assign dut_out = {PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, control_select, ifid_flush,
                     div_done, mem_fault, ctrl_state, stall_cycles};

   task automatic model_reset();
      m_fault = 0; m_waiting = 0; m_div_rem = 0; m_wait_len = 0; m_stall = 0;
   endtask

   function automatic bit model_mem_stall();
      return mem_req && !mem_ready && !m_fault;
   endfunction

   function automatic logic [25:0] model_out();
      logic [3:0] en;
      logic cs, fl, dd;
      logic [1:0] st;
      bit lu;
      if (!reset_n) return {4'b1111, 4'b0000, 2'b00, 16'd0};
      lu = ex_load_instr && ex_rf_enable && (rd_ex != 0) &&
           ((id_uses_rs && id_rs == rd_ex) || (id_uses_rt && id_rt == rd_ex));
      cs = 0; fl = 0;
      if (m_fault || model_mem_stall()) en = 4'b0000;
      else if (m_div_rem > 0 || lu) begin en = 4'b0011; cs = 1; end
      else if (branch_taken) begin en = 4'b1111; fl = 1; end
      else en = 4'b1111;
      dd = !m_fault && (m_div_rem == 1);
      st = m_fault ? 2'd3 : (m_div_rem > 0) ? 2'd2 : m_waiting ? 2'd1 : 2'd0;
      return {en, cs, fl, dd, m_fault, st, 16'(m_stall)};
   endfunction

   task automatic model_step();
      logic [25:0] o;
      bit stall;
      if (!reset_n) begin
         model_reset();
      end else begin
         o = model_out();
         stall = model_mem_stall();
         if (!o[25] && m_stall < 65535) m_stall++;
         if (m_fault) begin
         end else if (m_div_rem > 0) begin
            m_div_rem--;
            if (m_div_rem == 0 && stall) begin m_waiting = 1; m_wait_len = 1; end
         end else if (m_waiting) begin
            if (!stall) m_waiting = 0;
            else begin
               m_wait_len++;
               if (m_wait_len == MT) begin m_fault = 1; m_waiting = 0; end
            end
         end else if (stall) begin
            m_waiting = 1; m_wait_len = 1;
         end else if (div_start) begin
            m_div_rem = DL;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic set_idle();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
      ex_load_instr = 0; ex_rf_enable = 0; rd_ex = 0;
      branch_taken = 0; div_start = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic set_random();
      id_rs = 5'($urandom % 4); id_rt = 5'($urandom % 4); rd_ex = 5'($urandom % 4);
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      ex_load_instr = 1'($urandom); ex_rf_enable = ($urandom % 4) != 0;
      branch_taken = ($urandom % 4) == 0; div_start = ($urandom % 10) == 0;
      mem_req = ($urandom % 4) == 0; mem_ready = 1'($urandom);
   endtask

   task automatic test_reset();
      reset_n = 0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         set_random();
         mem_req = 1; mem_ready = 0;
         #2;
         total++;
         if (dut_out !== {4'b1111, 4'b0000, 2'b00, 16'd0}) begin
            bad++; $display("FAIL reset_values: got %h exp %h", dut_out, {4'b1111, 4'b0000, 2'b00, 16'd0});
         end
         tick();
      end
      set_idle();
      reset_n = 1;
      tick();
   endtask

   task automatic test_load_use();
      set_idle();
      ex_load_instr = 1; ex_rf_enable = 1; rd_ex = 5; id_rs = 5; id_uses_rs = 1;
      #2;
      total++;
      if ({PC_LE, IFID_LE, control_select, ctrl_state} !== 5'b00100) begin
         bad++; $display("FAIL load_use_stall: got %b exp 00100", {PC_LE, IFID_LE, control_select, ctrl_state});
      end
      total++;
      if (dut_out !== model_out()) begin
         bad++; $display("FAIL load_use_model: got %h exp %h", dut_out, model_out());
      end
      tick();
      set_idle();
      #2;
      total++;
      if (stall_cycles !== 16'd1 || ctrl_state !== 2'b00) begin
         bad++; $display("FAIL load_use_count: got %0d/%b exp 1/00", stall_cycles, ctrl_state);
      end
      ex_load_instr = 1; ex_rf_enable = 1; rd_ex = 0; id_rs = 0; id_uses_rs = 1; branch_taken = 1;
      #1;
      total++;
      if ({PC_LE, IFID_LE, control_select, ifid_flush} !== 4'b1101) begin
         bad++; $display("FAIL rd0_branch: got %b exp 1101", {PC_LE, IFID_LE, control_select, ifid_flush});
      end
      tick();
      set_idle();
   endtask

   task automatic test_divide();
      set_idle();
      div_start = 1;
      #2;
      tick();
      div_start = 0;
      for (int i = 0; i < DL; i++) begin
         #2;
         total++;
         if ({ctrl_state, control_select, PC_LE, IDEX_LE, div_done} !== {2'b10, 1'b1, 1'b0, 1'b1, 1'(i == DL - 1)}) begin
            bad++; $display("FAIL divide_cycle%0d: got %b exp %b", i,
               {ctrl_state, control_select, PC_LE, IDEX_LE, div_done}, {2'b10, 1'b1, 1'b0, 1'b1, 1'(i == DL - 1)});
         end
         tick();
      end
      #2;
      total++;
      if (ctrl_state !== 2'b00 || div_done !== 1'b0) begin
         bad++; $display("FAIL divide_end: got %b/%b exp 00/0", ctrl_state, div_done);
      end
   endtask

   task automatic test_mem_wait();
      int base;
      set_idle();
      base = m_stall;
      mem_req = 1; mem_ready = 0; branch_taken = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         total++;
         if ({PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, ifid_flush} !== 5'b00000) begin
            bad++; $display("FAIL mem_wait_freeze%0d: got %b exp 00000", i, {PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, ifid_flush});
         end
         tick();
      end
      mem_ready = 1; branch_taken = 0;
      #2;
      total++;
      if ({PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, ctrl_state} !== 6'b111101) begin
         bad++; $display("FAIL mem_wait_release: got %b exp 111101", {PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, ctrl_state});
      end
      tick();
      set_idle();
      #2;
      total++;
      if (stall_cycles !== 16'(base + 3) || ctrl_state !== 2'b00) begin
         bad++; $display("FAIL mem_wait_count: got %0d/%b exp %0d/00", stall_cycles, ctrl_state, base + 3);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         set_random();
         #2;
         total++;
         if (dut_out !== model_out()) begin
            bad++; $display("FAIL random_cycle%0d: got %h exp %h", i, dut_out, model_out());
         end
         tick();
      end
      set_idle();
   endtask

   task automatic test_reset_mid_divide();
      set_idle();
      div_start = 1;
      #2;
      tick();
      div_start = 0;
      tick(); tick(); tick();
      mem_req = 1; mem_ready = 0;
      #1;
      reset_n = 0;
      model_reset();
      #1;
      total++;
      if ({ctrl_state, div_done, PC_LE, stall_cycles} !== {2'b00, 1'b0, 1'b1, 16'd0}) begin
         bad++; $display("FAIL reset_mid_divide: got %h exp %h", {ctrl_state, div_done, PC_LE, stall_cycles}, {2'b00, 1'b0, 1'b1, 16'd0});
      end
      tick();
      set_idle();
      reset_n = 1;
      tick();
   endtask

   task automatic test_timeout_saturation();
      set_idle();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < MT; i++) begin
         #2;
         total++;
         if (dut_out !== model_out() || ctrl_state === 2'b11) begin
            bad++; $display("FAIL timeout_wait%0d: got %h exp %h", i, dut_out, model_out());
         end
         tick();
      end
      set_idle();
      #2;
      total++;
      if ({ctrl_state, mem_fault, PC_LE} !== 4'b1110) begin
         bad++; $display("FAIL timeout_fault: got %b exp 1110", {ctrl_state, mem_fault, PC_LE});
      end
      for (int i = 0; i < 65600; i++) begin
         set_random();
         #2;
         if (i % 4096 == 0) begin
            total++;
            if (dut_out !== model_out()) begin
               bad++; $display("FAIL fault_hold%0d: got %h exp %h", i, dut_out, model_out());
            end
         end
         tick();
      end
      set_idle();
      #2;
      total++;
      if ({stall_cycles, ctrl_state, mem_fault} !== {16'hFFFF, 2'b11, 1'b1}) begin
         bad++; $display("FAIL saturation: got %h exp %h", {stall_cycles, ctrl_state, mem_fault}, {16'hFFFF, 2'b11, 1'b1});
      end
      reset_n = 0;
      model_reset();
      #1;
      total++;
      if ({stall_cycles, ctrl_state, mem_fault} !== {16'h0000, 2'b00, 1'b0}) begin
         bad++; $display("FAIL fault_clear: got %h exp %h", {stall_cycles, ctrl_state, mem_fault}, {16'h0000, 2'b00, 1'b0});
      end
      tick();
      reset_n = 1;
      tick();
   endtask

   initial begin
      reset_n = 0;
      set_idle();
      model_reset();
      @(negedge clk);
      test_reset();
      test_load_use();
      test_divide();
      test_mem_wait();
      test_random();
      test_reset_mid_divide();
      test_timeout_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
